// File: rtl/desc_alloc_tracker.sv
// Descriptor free-list owner: feeds the first-free grant controller, turns its grants into
// one-per-request allocations, and takes completions back. Optional DESC_ALLOC_ERR_EN adds a sticky error flag.
module desc_alloc_tracker #(
    parameter int MAX_DESC   = 16,
    parameter int SETTLE_CYC = 3,
    parameter int IDX_W      = $clog2(MAX_DESC),
    parameter int CNT_W      = $clog2(MAX_DESC + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [MAX_DESC-1:0] free_vec,
    input  logic                gnt_vld,
    input  logic [IDX_W-1:0]    gnt_idx,
    input  logic                alloc_req,
    output logic                alloc_ack,
    output logic [IDX_W-1:0]    alloc_idx,
    input  logic                free_vld,
    input  logic [IDX_W-1:0]    free_idx,
    output logic [CNT_W-1:0]    busy_cnt,
    output logic                all_busy,
    output logic                alloc_err
);

    localparam int DEPTH = 1 << IDX_W;
    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam logic [IDX_W:0]   NUM_IDX = (IDX_W + 1)'(MAX_DESC);
    localparam logic [CNT_W-1:0] FULL    = CNT_W'(MAX_DESC);

    typedef enum logic [1:0] {IDLE, WAIT_GNT, SETTLE} state_t;

    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
    } slot_upd_t;

    state_t           state, state_nxt;
    logic [SET_W-1:0] cnt, cnt_nxt;

    logic [DEPTH-1:0]    free_pad;
    logic [MAX_DESC-1:0] free_nxt;
    logic [CNT_W-1:0]    busy_nxt;
    logic                gnt_in_rng, free_in_rng;
    slot_upd_t           take, give;

    // Padding with zeros makes unimplemented indices read as "not free" when indexing.
    assign free_pad    = DEPTH'(free_vec);
    assign gnt_in_rng  = {1'b0, gnt_idx} < NUM_IDX;
    assign free_in_rng = {1'b0, free_idx} < NUM_IDX;

    assign take.vld = (state == WAIT_GNT) && alloc_req && gnt_vld && gnt_in_rng && free_pad[gnt_idx];
    assign take.idx = gnt_idx;
    assign give.vld = free_vld && free_in_rng && !free_pad[free_idx];
    assign give.idx = free_idx;

    always_comb begin
        free_nxt = free_vec;
        for (int i = 0; i < MAX_DESC; i++) begin
            if (take.vld && take.idx == IDX_W'(i)) free_nxt[i] = 1'b0;
            if (give.vld && give.idx == IDX_W'(i)) free_nxt[i] = 1'b1;
        end
    end

    always_comb begin
        busy_nxt = busy_cnt;
        case ({take.vld, give.vld})
            2'b10:   busy_nxt = busy_cnt + CNT_W'(1);
            2'b01:   busy_nxt = busy_cnt - CNT_W'(1);
            default: busy_nxt = busy_cnt;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: if (alloc_req) state_nxt = WAIT_GNT;
            WAIT_GNT: begin
                if (!alloc_req) begin
                    state_nxt = IDLE;
                end else if (take.vld) begin
                    state_nxt = SETTLE;
                    cnt_nxt   = SET_W'(SETTLE_CYC);
                end
            end
            SETTLE: begin
                // Grants are stale until the controller pipeline has seen the new free vector.
                if (cnt == '0) state_nxt = alloc_req ? WAIT_GNT : IDLE;
                else           cnt_nxt   = cnt - SET_W'(1);
            end
            default: state_nxt = SETTLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= SETTLE;
            cnt   <= SET_W'(SETTLE_CYC);
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            free_vec  <= '1;
            alloc_ack <= 1'b0;
            alloc_idx <= '0;
            busy_cnt  <= '0;
            all_busy  <= 1'b0;
        end else begin
            free_vec  <= free_nxt;
            alloc_ack <= take.vld;
            if (take.vld) alloc_idx <= take.idx;
            busy_cnt  <= busy_nxt;
            all_busy  <= (busy_nxt == FULL);
        end
    end

`ifdef DESC_ALLOC_ERR_EN
    logic err_evt;
    assign err_evt = (free_vld && (!free_in_rng || free_pad[free_idx]))
                   || ((state == WAIT_GNT) && gnt_vld && !gnt_in_rng);

    always_ff @(posedge clk) begin
        if (!rst_n)       alloc_err <= 1'b0;
        else if (err_evt) alloc_err <= 1'b1;
    end
`else
    assign alloc_err = 1'b0;
`endif

endmodule

// File: tb/tb_desc_alloc_tracker.sv
// Directed bench for desc_alloc_tracker: a 16-entry instance with a modelled two-stage
// first-free grant controller, plus a 6-entry instance for out-of-range indices.
module tb_desc_alloc_tracker;

`ifdef DESC_ALLOC_ERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif
    localparam int SC = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          total = 0;
    int          bad = 0;

    // 16-entry instance
    logic [15:0] free_vec;
    logic        gnt_vld, alloc_req = 1'b0, alloc_ack, all_busy, alloc_err;
    logic [3:0]  gnt_idx, alloc_idx, free_idx = '0;
    logic        free_vld = 1'b0;
    logic [4:0]  busy_cnt;
    logic        loop_sel = 1'b0, drv_vld = 1'b0;
    logic [3:0]  drv_idx = '0;
    logic [15:0] m_d1 = '1;
    logic        m_vld = 1'b0;
    logic [3:0]  m_idx = '0;

    // 6-entry instance
    logic [5:0]  s_free_vec;
    logic        s_gnt_vld = 1'b0, s_req = 1'b0, s_ack, s_free_vld = 1'b0, s_all_busy, s_err;
    logic [2:0]  s_gnt_idx = '0, s_idx, s_free_idx = '0, s_busy;

    always #5 clk = ~clk;

    function automatic logic [3:0] lowest(input logic [15:0] d);
        lowest = '0;
        for (int i = 15; i >= 0; i--) if (d[i]) lowest = 4'(i);
    endfunction

    // Grant controller: register din, then register first-free of it.
    always @(posedge clk) begin
        m_d1  <= free_vec;
        m_vld <= |m_d1;
        m_idx <= lowest(m_d1);
    end

    assign gnt_vld = loop_sel ? m_vld : drv_vld;
    assign gnt_idx = loop_sel ? m_idx : drv_idx;

    desc_alloc_tracker #(.MAX_DESC(16), .SETTLE_CYC(SC)) u_dut (
        .clk(clk), .rst_n(rst_n), .free_vec(free_vec), .gnt_vld(gnt_vld), .gnt_idx(gnt_idx),
        .alloc_req(alloc_req), .alloc_ack(alloc_ack), .alloc_idx(alloc_idx),
        .free_vld(free_vld), .free_idx(free_idx), .busy_cnt(busy_cnt),
        .all_busy(all_busy), .alloc_err(alloc_err)
    );

    desc_alloc_tracker #(.MAX_DESC(6), .SETTLE_CYC(SC)) u_small (
        .clk(clk), .rst_n(rst_n), .free_vec(s_free_vec), .gnt_vld(s_gnt_vld), .gnt_idx(s_gnt_idx),
        .alloc_req(s_req), .alloc_ack(s_ack), .alloc_idx(s_idx),
        .free_vld(s_free_vld), .free_idx(s_free_idx), .busy_cnt(s_busy),
        .all_busy(s_all_busy), .alloc_err(s_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        total++; if (free_vec !== 16'hFFFF) begin bad++; $display("FAIL rst_free_vec got=%h exp=ffff", free_vec); end
        total++; if (alloc_ack !== 1'b0) begin bad++; $display("FAIL rst_ack got=%b exp=0", alloc_ack); end
        total++; if (alloc_idx !== 4'd0) begin bad++; $display("FAIL rst_idx got=%0d exp=0", alloc_idx); end
        total++; if (busy_cnt !== 5'd0) begin bad++; $display("FAIL rst_busy got=%0d exp=0", busy_cnt); end
        total++; if (all_busy !== 1'b0) begin bad++; $display("FAIL rst_all_busy got=%b exp=0", all_busy); end
        total++; if (alloc_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", alloc_err); end
    endtask

    task automatic test_fill();
        int n, last, extra;
        n = 0; last = 0; extra = 0;
        loop_sel = 1'b1; alloc_req = 1'b1; rst_n = 1'b1;
        for (int t = 1; t <= 200 && n < 16; t++) begin
            tick();
            if (alloc_ack === 1'b1) begin
                total++;
                if (alloc_idx !== 4'(n)) begin bad++; $display("FAIL fill_idx ack#%0d got=%0d exp=%0d", n, alloc_idx, n); end
                total++;
                if (n == 0 && t <= SC) begin bad++; $display("FAIL fill_settle first ack at cycle %0d exp>%0d", t, SC); end
                else if (n > 0 && t - last < SC + 2) begin bad++; $display("FAIL fill_spacing got=%0d exp>=%0d", t - last, SC + 2); end
                last = t; n++;
            end
        end
        total++; if (n != 16) begin bad++; $display("FAIL fill_count got=%0d exp=16", n); end
        repeat (20) begin tick(); if (alloc_ack === 1'b1) extra++; end
        total++; if (extra != 0) begin bad++; $display("FAIL full_no_ack got=%0d acks exp=0", extra); end
        total++; if (busy_cnt !== 5'd16) begin bad++; $display("FAIL full_busy got=%0d exp=16", busy_cnt); end
        total++; if (all_busy !== 1'b1) begin bad++; $display("FAIL full_all_busy got=%b exp=1", all_busy); end
        total++; if (free_vec !== 16'h0000) begin bad++; $display("FAIL full_free_vec got=%h exp=0000", free_vec); end
    endtask

    task automatic test_free_realloc();
        free_vld = 1'b1; free_idx = 4'd5;
        tick();
        free_vld = 1'b0;
        total++; if (free_vec !== 16'h0020) begin bad++; $display("FAIL free5_vec got=%h exp=0020", free_vec); end
        total++; if (busy_cnt !== 5'd15) begin bad++; $display("FAIL free5_busy got=%0d exp=15", busy_cnt); end
        total++; if (all_busy !== 1'b0) begin bad++; $display("FAIL free5_all_busy got=%b exp=0", all_busy); end
        for (int k = 0; k < 50 && alloc_ack !== 1'b1; k++) tick();
        total++; if (alloc_ack !== 1'b1) begin bad++; $display("FAIL realloc_timeout got ack=%b exp=1", alloc_ack); end
        total++; if (alloc_idx !== 4'd5) begin bad++; $display("FAIL realloc_idx got=%0d exp=5", alloc_idx); end
        total++; if (busy_cnt !== 5'd16 || all_busy !== 1'b1) begin bad++; $display("FAIL realloc_busy got=%0d/%b exp=16/1", busy_cnt, all_busy); end
    endtask

    task automatic test_simul();
        int n;
        n = 0;
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        for (int k = 0; k < 100 && n < 4; k++) begin tick(); if (alloc_ack === 1'b1) n++; end
        total++; if (n != 4) begin bad++; $display("FAIL simul_setup got=%0d acks exp=4", n); end
        // The next accept (idx 4) lands exactly SETTLE_CYC+2 edges after the last ack.
        repeat (SC + 1) tick();
        free_vld = 1'b1; free_idx = 4'd2;
        tick();
        free_vld = 1'b0;
        total++; if (alloc_ack !== 1'b1 || alloc_idx !== 4'd4) begin bad++; $display("FAIL simul_ack got=%b/%0d exp=1/4", alloc_ack, alloc_idx); end
        total++; if (free_vec !== 16'hFFE4) begin bad++; $display("FAIL simul_vec got=%h exp=ffe4", free_vec); end
        total++; if (busy_cnt !== 5'd4) begin bad++; $display("FAIL simul_busy got=%0d exp=4", busy_cnt); end
        tick();
        for (int k = 0; k < 50 && alloc_ack !== 1'b1; k++) tick();
        total++; if (alloc_ack !== 1'b1 || alloc_idx !== 4'd2) begin bad++; $display("FAIL simul_next got=%b/%0d exp=1/2", alloc_ack, alloc_idx); end
        total++; if (busy_cnt !== 5'd5) begin bad++; $display("FAIL simul_next_busy got=%0d exp=5", busy_cnt); end
        alloc_req = 1'b0;
    endtask

    task automatic test_stale_grant();
        int extra;
        extra = 0;
        rst_n = 1'b0; loop_sel = 1'b0; drv_vld = 1'b1; drv_idx = 4'd3; alloc_req = 1'b1;
        tick(); rst_n = 1'b1;
        for (int k = 0; k < 20 && alloc_ack !== 1'b1; k++) tick();
        total++; if (alloc_ack !== 1'b1 || alloc_idx !== 4'd3) begin bad++; $display("FAIL stale_first got=%b/%0d exp=1/3", alloc_ack, alloc_idx); end
        repeat (12) begin tick(); if (alloc_ack === 1'b1) extra++; end
        total++; if (extra != 0 || busy_cnt !== 5'd1) begin bad++; $display("FAIL stale_hold acks=%0d busy=%0d exp=0/1", extra, busy_cnt); end
        drv_idx = 4'd6;
        for (int k = 0; k < 20 && alloc_ack !== 1'b1; k++) tick();
        total++; if (alloc_ack !== 1'b1 || alloc_idx !== 4'd6) begin bad++; $display("FAIL stale_then6 got=%b/%0d exp=1/6", alloc_ack, alloc_idx); end
        alloc_req = 1'b0; drv_idx = 4'd7; extra = 0;
        repeat (12) begin tick(); if (alloc_ack === 1'b1) extra++; end
        total++; if (extra != 0 || busy_cnt !== 5'd2) begin bad++; $display("FAIL noreq_hold acks=%0d busy=%0d exp=0/2", extra, busy_cnt); end
        total++; if (free_vec !== 16'hFFB7) begin bad++; $display("FAIL noreq_vec got=%h exp=ffb7", free_vec); end
        drv_vld = 1'b0;
    endtask

    task automatic test_bad_free();
        free_vld = 1'b1; free_idx = 4'd7;
        tick();
        free_vld = 1'b0;
        total++; if (free_vec !== 16'hFFB7 || busy_cnt !== 5'd2) begin bad++; $display("FAIL dblfree got=%h/%0d exp=ffb7/2", free_vec, busy_cnt); end
        total++; if (alloc_err !== EXP_ERR) begin bad++; $display("FAIL dblfree_err got=%b exp=%b", alloc_err, EXP_ERR); end
        free_vld = 1'b1; free_idx = 4'd3;
        tick();
        free_vld = 1'b0;
        total++; if (free_vec !== 16'hFFBF || busy_cnt !== 5'd1) begin bad++; $display("FAIL goodfree got=%h/%0d exp=ffbf/1", free_vec, busy_cnt); end
        total++; if (alloc_err !== EXP_ERR) begin bad++; $display("FAIL err_sticky got=%b exp=%b", alloc_err, EXP_ERR); end
    endtask

    task automatic test_small_range();
        int extra;
        extra = 0;
        s_free_vld = 1'b1; s_free_idx = 3'd6;
        tick();
        s_free_idx = 3'd7;
        tick();
        s_free_vld = 1'b0;
        total++; if (s_free_vec !== 6'h3F || s_busy !== 3'd0) begin bad++; $display("FAIL oor_free got=%h/%0d exp=3f/0", s_free_vec, s_busy); end
        total++; if (s_err !== EXP_ERR) begin bad++; $display("FAIL oor_free_err got=%b exp=%b", s_err, EXP_ERR); end
        s_req = 1'b1; s_gnt_vld = 1'b1; s_gnt_idx = 3'd7;
        repeat (12) begin tick(); if (s_ack === 1'b1) extra++; end
        total++; if (extra != 0 || s_busy !== 3'd0) begin bad++; $display("FAIL oor_gnt acks=%0d busy=%0d exp=0/0", extra, s_busy); end
        s_gnt_idx = 3'd5;
        for (int k = 0; k < 20 && s_ack !== 1'b1; k++) tick();
        total++; if (s_ack !== 1'b1 || s_idx !== 3'd5) begin bad++; $display("FAIL small_alloc got=%b/%0d exp=1/5", s_ack, s_idx); end
        total++; if (s_free_vec !== 6'h1F || s_busy !== 3'd1) begin bad++; $display("FAIL small_state got=%h/%0d exp=1f/1", s_free_vec, s_busy); end
        s_req = 1'b0; s_gnt_vld = 1'b0;
    endtask

    task automatic test_reset_mid();
        int t;
        t = 0;
        rst_n = 1'b0; loop_sel = 1'b1; alloc_req = 1'b1;
        tick(); rst_n = 1'b1;
        for (int k = 0; k < 20 && alloc_ack !== 1'b1; k++) tick();
        total++; if (alloc_ack !== 1'b1 || busy_cnt !== 5'd1) begin bad++; $display("FAIL mid_setup got=%b/%0d exp=1/1", alloc_ack, busy_cnt); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total++; if (alloc_ack !== 1'b0 || free_vec !== 16'hFFFF) begin bad++; $display("FAIL mid_rst got=%b/%h exp=0/ffff", alloc_ack, free_vec); end
        total++; if (busy_cnt !== 5'd0 || all_busy !== 1'b0 || alloc_err !== 1'b0) begin bad++; $display("FAIL mid_rst_cnt got=%0d/%b/%b exp=0/0/0", busy_cnt, all_busy, alloc_err); end
        for (int k = 1; k <= 20 && t == 0; k++) begin tick(); if (alloc_ack === 1'b1) t = k; end
        total++; if (t <= SC || alloc_idx !== 4'd0) begin bad++; $display("FAIL mid_resettle ack at %0d idx=%0d exp>%0d/0", t, alloc_idx, SC); end
        alloc_req = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_free_realloc();
        test_simul();
        test_stale_grant();
        test_bad_free();
        test_small_range();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
